// File: rtl/sdram_sched_pkg.sv
// Shared types and helpers for the SDRAM round-robin scheduler.
// Holds the FSM state encoding and the timer width calculation.
package sdram_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  function automatic int timer_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set request
// at or after ptr, searching upward modulo N_PORTS.
module rr_pick #(
  parameter int N_PORTS = 4,
  parameter int IW      = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [IW-1:0]      idx,
  output logic               valid
);

  always_comb begin
    int p;
    p     = 0;
    idx   = '0;
    valid = 1'b0;
    for (int k = 0; k < N_PORTS; k++) begin
      p = (int'(ptr) + k) % N_PORTS;
      if (!valid && req[p]) begin
        valid = 1'b1;
        idx   = IW'(p);
      end
    end
  end

endmodule

// File: rtl/sdram_rr_sched.sv
// Round-robin scheduler sharing one SDRAM core request port among
// N_PORTS requesters, with a watchdog that aborts stalled transactions.
module sdram_rr_sched
  import sdram_sched_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 16,
  parameter int LEN_W   = 8,
  parameter int WR_W    = DATA_W / 8,
  parameter int TIMEOUT = 1023,
  parameter int IW      = $clog2(N_PORTS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_PORTS-1:0]          req_rd,
  input  logic [N_PORTS*WR_W-1:0]     req_wr,
  input  logic [N_PORTS*LEN_W-1:0]    req_len,
  input  logic [N_PORTS*ADDR_W-1:0]   req_addr,
  input  logic [N_PORTS*DATA_W-1:0]   req_wdata,
  output logic [N_PORTS-1:0]          port_accept,
  output logic [N_PORTS-1:0]          port_ack,
  output logic [N_PORTS-1:0]          port_error,
  output logic [N_PORTS*DATA_W-1:0]   port_rdata,
  output logic                        core_rd,
  output logic [WR_W-1:0]             core_wr,
  output logic [LEN_W-1:0]            core_len,
  output logic [ADDR_W-1:0]           core_addr,
  output logic [DATA_W-1:0]           core_wdata,
  input  logic                        core_accept,
  input  logic                        core_ack,
  input  logic                        core_error,
  input  logic [DATA_W-1:0]           core_rdata,
  output logic                        core_abort,
  output logic                        busy,
  output logic [IW-1:0]               grant_idx
);

  localparam int TW = timer_width(TIMEOUT);

  state_e          state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic [N_PORTS-1:0] req_vec;
  logic [IW-1:0]      pick_idx;
  logic               pick_valid;

  logic               g_rd;
  logic [WR_W-1:0]    g_wr;
  logic [LEN_W-1:0]   g_len;
  logic [ADDR_W-1:0]  g_addr;
  logic [DATA_W-1:0]  g_wdata;
  logic [IW-1:0]      next_ptr;
  logic [TW-1:0]      timer_inc;

  always_comb begin
    req_vec = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      req_vec[i] = req_rd[i] | (|req_wr[i*WR_W +: WR_W]);
    end
  end

  rr_pick #(
    .N_PORTS (N_PORTS),
    .IW      (IW)
  ) u_pick (
    .req   (req_vec),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign g_rd      = req_rd[grant_q];
  assign g_wr      = req_wr[grant_q*WR_W +: WR_W];
  assign g_len     = req_len[grant_q*LEN_W +: LEN_W];
  assign g_addr    = req_addr[grant_q*ADDR_W +: ADDR_W];
  assign g_wdata   = req_wdata[grant_q*DATA_W +: DATA_W];
  assign next_ptr  = (grant_q == IW'(N_PORTS - 1)) ? '0 : grant_q + 1'b1;
  assign timer_inc = (timer_q == TW'(TIMEOUT)) ? timer_q : timer_q + 1'b1;

  // Same-cycle ack/error on accept completes the transaction straight from ISSUE.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    timer_d     = timer_q;
    port_accept = '0;
    port_ack    = '0;
    port_error  = '0;
    port_rdata  = '0;
    core_rd     = 1'b0;
    core_wr     = '0;
    core_len    = '0;
    core_addr   = '0;
    core_wdata  = '0;
    core_abort  = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        core_rd              = g_rd;
        core_wr              = g_wr;
        core_len             = g_len;
        core_addr            = g_addr;
        core_wdata           = g_wdata;
        port_accept[grant_q] = core_accept;
        if (core_accept) begin
          timer_d = '0;
          if (core_ack || core_error) begin
            port_ack[grant_q]                   = core_ack;
            port_error[grant_q]                 = core_error;
            port_rdata[grant_q*DATA_W +: DATA_W] = core_rdata;
            ptr_d                               = next_ptr;
            state_d                             = IDLE;
          end else begin
            state_d = WAIT;
          end
        end else if (!req_vec[grant_q]) begin
          state_d = IDLE;
        end
      end

      WAIT: begin
        core_wdata                          = g_wdata;
        port_ack[grant_q]                   = core_ack;
        port_error[grant_q]                 = core_error;
        port_rdata[grant_q*DATA_W +: DATA_W] = core_rdata;
        timer_d                             = timer_inc;
        if (core_ack || core_error) begin
          ptr_d   = next_ptr;
          state_d = IDLE;
        end else if (timer_inc == TW'(TIMEOUT)) begin
          core_abort          = 1'b1;
          port_error[grant_q] = 1'b1;
          ptr_d               = next_ptr;
          state_d             = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      timer_q <= timer_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign grant_idx = grant_q;

endmodule
